// File: rtl/color_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : color_sensor_emulator
//  Description : Emulates the colour sensor square wave with a programmable
//                high/low period per filter channel selected by filtro_sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module color_sensor_emulator #(
  parameter logic [31:0] DEF_HI_RED   = 32'd20500,
  parameter logic [31:0] DEF_HI_BLUE  = 32'd8000,
  parameter logic [31:0] DEF_HI_CLEAR = 32'd5000,
  parameter logic [31:0] DEF_HI_GREEN = 32'd14000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  filtro_sel,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_chan,
  input  logic [31:0] cfg_high,
  input  logic [31:0] cfg_low,
  output logic        sensor_clk,
  output logic        cycle_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_tab_hi [4];
  logic [31:0] r_tab_lo [4];
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] r_lo_lat;
  logic [31:0] w_lo_lat_nxt;
  logic [31:0] w_sel_hi;
  logic [31:0] w_sel_lo;
  logic        r_sensor_clk;
  logic        r_cycle_done;
  logic        w_write;

  assign cfg_ready  = ~rst;
  assign w_write    = cfg_valid & cfg_ready;
  assign sensor_clk = r_sensor_clk;
  assign cycle_done = r_cycle_done;

  // Clamped view of the selected entry; reads the pre-write table contents
  assign w_sel_hi = (r_tab_hi[filtro_sel] == 32'd0) ? 32'd1 : r_tab_hi[filtro_sel];
  assign w_sel_lo = (r_tab_lo[filtro_sel] == 32'd0) ? 32'd1 : r_tab_lo[filtro_sel];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lo_lat_nxt = r_lo_lat;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = w_sel_hi - 32'd1;
          w_lo_lat_nxt = w_sel_lo;
        end
      end
      S_HIGH: begin
        if (r_cnt == 32'd0) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = r_lo_lat - 32'd1;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      S_LOW: begin
        if (r_cnt == 32'd0) begin
          // Back-to-back periods: relatch so the next high starts without a gap
          if (enable) begin
            w_state_nxt  = S_HIGH;
            w_cnt_nxt    = w_sel_hi - 32'd1;
            w_lo_lat_nxt = w_sel_lo;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 32'd0;
      r_lo_lat     <= 32'd0;
      r_sensor_clk <= 1'b0;
      r_cycle_done <= 1'b0;
      r_tab_hi[0]  <= DEF_HI_RED;
      r_tab_lo[0]  <= DEF_HI_RED;
      r_tab_hi[1]  <= DEF_HI_BLUE;
      r_tab_lo[1]  <= DEF_HI_BLUE;
      r_tab_hi[2]  <= DEF_HI_CLEAR;
      r_tab_lo[2]  <= DEF_HI_CLEAR;
      r_tab_hi[3]  <= DEF_HI_GREEN;
      r_tab_lo[3]  <= DEF_HI_GREEN;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lo_lat     <= w_lo_lat_nxt;
      r_sensor_clk <= (w_state_nxt == S_HIGH);
      r_cycle_done <= (w_state_nxt == S_LOW) && (w_cnt_nxt == 32'd0);
      if (w_write) begin
        r_tab_hi[cfg_chan] <= cfg_high;
        r_tab_lo[cfg_chan] <= cfg_low;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_sensor_emulator
//  Description : Directed plus randomized bench for color_sensor_emulator
//                against a waveform-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_color_sensor_emulator;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  filtro_sel = 2'd0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = 2'd0;
  logic [31:0] cfg_high = 32'd0;
  logic [31:0] cfg_low = 32'd0;
  logic        sensor_clk;
  logic        cycle_done;

  int checks = 0;
  int errors = 0;

  // Model: table plus the remaining waveform of the running period, as {sensor_clk, cycle_done}
  logic [31:0] m_hi [4];
  logic [31:0] m_lo [4];
  logic [1:0]  m_q [$];

  always #5 mclk = ~mclk;

  color_sensor_emulator dut (
    .mclk       (mclk),
    .rst        (rst),
    .enable     (enable),
    .filtro_sel (filtro_sel),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .sensor_clk (sensor_clk),
    .cycle_done (cycle_done)
  );

  task automatic model_defaults();
    m_hi[0] = 32'd20500; m_lo[0] = 32'd20500;
    m_hi[1] = 32'd8000;  m_lo[1] = 32'd8000;
    m_hi[2] = 32'd5000;  m_lo[2] = 32'd5000;
    m_hi[3] = 32'd14000; m_lo[3] = 32'd14000;
  endtask

  task automatic model_edge();
    logic [31:0] h;
    logic [31:0] l;
    if (rst) begin
      m_q.delete();
      model_defaults();
    end else begin
      if (m_q.size() <= 1) begin
        m_q.delete();
        if (enable) begin
          h = (m_hi[filtro_sel] == 0) ? 32'd1 : m_hi[filtro_sel];
          l = (m_lo[filtro_sel] == 0) ? 32'd1 : m_lo[filtro_sel];
          for (int i = 0; i < int'(h); i++) m_q.push_back(2'b10);
          for (int i = 0; i < int'(l) - 1; i++) m_q.push_back(2'b00);
          m_q.push_back(2'b01);
        end
      end else begin
        void'(m_q.pop_front());
      end
      if (cfg_valid) begin
        m_hi[cfg_chan] = cfg_high;
        m_lo[cfg_chan] = cfg_low;
      end
    end
  endtask

  // One clock: model advances on the edge with the inputs driven before it, DUT compared on the falling edge
  task automatic step(input int n);
    logic [1:0] exp;
    for (int k = 0; k < n; k++) begin
      @(posedge mclk);
      model_edge();
      @(negedge mclk);
      exp = (m_q.size() != 0) ? m_q[0] : 2'b00;
      checks++;
      assert (sensor_clk === exp[1]) else begin
        errors++;
        $error("FAIL sensor_clk t=%0t observed=%b expected=%b", $time, sensor_clk, exp[1]);
      end
      checks++;
      assert (cycle_done === exp[0]) else begin
        errors++;
        $error("FAIL cycle_done t=%0t observed=%b expected=%b", $time, cycle_done, exp[0]);
      end
      checks++;
      assert (cfg_ready === ~rst) else begin
        errors++;
        $error("FAIL cfg_ready t=%0t observed=%b expected=%b", $time, cfg_ready, ~rst);
      end
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [31:0] hi, input logic [31:0] lo);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_high = hi; cfg_low = lo;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    model_defaults();
    // Reset state
    step(3);
    rst = 1'b0;
    step(2);

    // Default red channel: 20500 high / 20500 low, continuous restart
    filtro_sel = 2'b00; enable = 1'b1;
    step(41050);

    // Green entry reprogrammed to 15000/3000
    do_reset();
    write_cfg(2'b11, 32'd15000, 32'd3000);
    filtro_sel = 2'b11; enable = 1'b1;
    step(18020);

    // Mid-period select change must wait for the next boundary
    do_reset();
    write_cfg(2'b00, 32'd300, 32'd200);
    write_cfg(2'b01, 32'd50, 32'd40);
    filtro_sel = 2'b00; enable = 1'b1;
    step(100);
    filtro_sel = 2'b01;
    step(600);

    // Zero entries clamp to 1/1; write coinciding with a period start uses old value
    do_reset();
    write_cfg(2'b00, 32'd0, 32'd0);
    filtro_sel = 2'b00; enable = 1'b1;
    step(20);
    cfg_valid = 1'b1; cfg_chan = 2'b00; cfg_high = 32'd3; cfg_low = 32'd2;
    step(1);
    cfg_valid = 1'b0;
    step(20);

    // Enable dropped during LOW: period completes, idle, then immediate restart
    do_reset();
    write_cfg(2'b00, 32'd5, 32'd7);
    filtro_sel = 2'b00; enable = 1'b1;
    step(8);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(30);

    // Reset in HIGH after reprogramming restores defaults
    do_reset();
    write_cfg(2'b00, 32'd1000, 32'd1000);
    filtro_sel = 2'b00; enable = 1'b1;
    step(500);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1100);

    // Randomized traffic with short entries
    do_reset();
    for (int c = 0; c < 4; c++) write_cfg(c[1:0], $urandom_range(0, 12), $urandom_range(0, 12));
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 15) == 0) filtro_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_high  = $urandom_range(0, 12);
      cfg_low   = $urandom_range(0, 12);
      rst       = ($urandom_range(0, 700) == 0);
      step(1);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
